// File: rtl/poly_horner_sequencer.sv
// rtl/poly_horner_sequencer.sv - Horner-rule float32 polynomial sequencer driving shared mul/add units
// Control half only: operands go out to external valid-only units, results come back bit-exact.
module poly_horner_sequencer #(
  parameter int G_POLY_ORDER = 5,
  parameter int G_TIMEOUT    = 64,
  parameter int G_AWIDTH     = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_coef_wr_en,
  input  logic [G_AWIDTH-1:0] i_coef_wr_addr,
  input  logic [31:0]         i_coef_wr_data,
  input  logic [31:0]         i_din,
  input  logic                i_din_valid,
  output logic                o_din_ready,
  output logic [31:0]         o_dout,
  output logic                o_dout_valid,
  input  logic                i_dout_ready,
  output logic [31:0]         o_mul_din1,
  output logic [31:0]         o_mul_din2,
  output logic                o_mul_din_valid,
  input  logic [31:0]         i_mul_dout,
  input  logic                i_mul_dout_valid,
  output logic [31:0]         o_add_din1,
  output logic [31:0]         o_add_din2,
  output logic                o_add_din_valid,
  input  logic [31:0]         i_add_dout,
  input  logic                i_add_dout_valid,
  output logic                o_busy,
  output logic                o_timeout_err
);

  localparam int C_TW    = $clog2(G_TIMEOUT + 1);
  localparam int C_DEPTH = 1 << G_AWIDTH;
  localparam logic [C_TW-1:0]     C_TMO_LAST = C_TW'(G_TIMEOUT - 1);
  localparam logic [G_AWIDTH-1:0] C_N        = G_AWIDTH'(G_POLY_ORDER);

  localparam logic [2:0] SM_INIT        = 3'd0;
  localparam logic [2:0] SM_GET_INPUT   = 3'd1;
  localparam logic [2:0] SM_MUL_ISSUE   = 3'd2;
  localparam logic [2:0] SM_MUL_WAIT    = 3'd3;
  localparam logic [2:0] SM_ADD_ISSUE   = 3'd4;
  localparam logic [2:0] SM_ADD_WAIT    = 3'd5;
  localparam logic [2:0] SM_SEND_OUTPUT = 3'd6;

  logic [2:0]          r_state;
  logic [2:0]          w_next;
  logic [31:0]         r_coef [C_DEPTH];
  logic [31:0]         r_x;
  logic [31:0]         r_acc;
  logic [31:0]         r_dout;
  logic [31:0]         r_mul_din1;
  logic [31:0]         r_mul_din2;
  logic [31:0]         r_add_din1;
  logic [31:0]         r_add_din2;
  logic [G_AWIDTH-1:0] r_k;
  logic [C_TW-1:0]     r_tmo;
  logic                r_din_ready;
  logic                r_dout_valid;
  logic                r_mul_din_valid;
  logic                r_add_din_valid;
  logic                r_busy;
  logic                r_timeout_err;
  logic                w_coef_we;
  logic                w_tmo_hit;
  logic                w_tmo_fire;
  logic [31:0]         w_cn;

  assign w_coef_we = i_coef_wr_en && (r_state == SM_GET_INPUT) && (i_coef_wr_addr <= C_N);
  // cN is consumed on the handshake cycle, so a same-cycle write must bypass the bank
  assign w_cn      = (w_coef_we && (i_coef_wr_addr == C_N)) ? i_coef_wr_data : r_coef[C_N];
  assign w_tmo_hit = (r_tmo == C_TMO_LAST);

  always_comb begin
    w_next     = r_state;
    w_tmo_fire = 1'b0;
    case (r_state)
      SM_INIT:      w_next = SM_GET_INPUT;
      SM_GET_INPUT: if (i_din_valid) w_next = SM_MUL_ISSUE;
      SM_MUL_ISSUE: w_next = SM_MUL_WAIT;
      SM_MUL_WAIT: begin
        if (i_mul_dout_valid) begin
          w_next = SM_ADD_ISSUE;
        end else if (w_tmo_hit) begin
          w_next     = SM_INIT;
          w_tmo_fire = 1'b1;
        end
      end
      SM_ADD_ISSUE: w_next = SM_ADD_WAIT;
      SM_ADD_WAIT: begin
        if (i_add_dout_valid) begin
          w_next = (r_k == '0) ? SM_SEND_OUTPUT : SM_MUL_ISSUE;
        end else if (w_tmo_hit) begin
          w_next     = SM_INIT;
          w_tmo_fire = 1'b1;
        end
      end
      SM_SEND_OUTPUT: if (i_dout_ready) w_next = SM_GET_INPUT;
      default:        w_next = SM_INIT;
    endcase
    if (!i_enable) begin
      w_next     = SM_INIT;
      w_tmo_fire = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < C_DEPTH; i++) r_coef[i] <= '0;
    end else if (w_coef_we) begin
      r_coef[i_coef_wr_addr] <= i_coef_wr_data;
    end
  end

  // Status and issue strobes are decoded from the next state so every output is a flop
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= SM_INIT;
      r_busy          <= 1'b1;
      r_din_ready     <= 1'b0;
      r_dout_valid    <= 1'b0;
      r_mul_din_valid <= 1'b0;
      r_add_din_valid <= 1'b0;
      r_timeout_err   <= 1'b0;
      r_tmo           <= '0;
      r_k             <= '0;
      r_x             <= '0;
      r_acc           <= '0;
      r_dout          <= '0;
      r_mul_din1      <= '0;
      r_mul_din2      <= '0;
      r_add_din1      <= '0;
      r_add_din2      <= '0;
    end else begin
      r_state         <= w_next;
      r_busy          <= (w_next != SM_GET_INPUT);
      r_din_ready     <= (w_next == SM_GET_INPUT);
      r_dout_valid    <= (w_next == SM_SEND_OUTPUT);
      r_mul_din_valid <= (w_next == SM_MUL_ISSUE);
      r_add_din_valid <= (w_next == SM_ADD_ISSUE);
      if ((r_state == SM_MUL_WAIT) || (r_state == SM_ADD_WAIT)) r_tmo <= r_tmo + 1'b1;
      else                                                      r_tmo <= '0;
      if (w_tmo_fire) r_timeout_err <= 1'b1;
      case (r_state)
        SM_INIT: r_acc <= '0;
        SM_GET_INPUT: begin
          if (w_next == SM_MUL_ISSUE) begin
            r_x        <= i_din;
            r_acc      <= w_cn;
            r_k        <= C_N - 1'b1;
            r_mul_din1 <= w_cn;
            r_mul_din2 <= i_din;
          end
        end
        SM_MUL_WAIT: begin
          if (w_next == SM_ADD_ISSUE) begin
            r_acc      <= i_mul_dout;
            r_add_din1 <= i_mul_dout;
            r_add_din2 <= r_coef[r_k];
          end
        end
        SM_ADD_WAIT: begin
          if (w_next == SM_MUL_ISSUE) begin
            r_acc      <= i_add_dout;
            r_k        <= r_k - 1'b1;
            r_mul_din1 <= i_add_dout;
            r_mul_din2 <= r_x;
          end else if (w_next == SM_SEND_OUTPUT) begin
            r_acc  <= i_add_dout;
            r_dout <= i_add_dout;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_din_ready     = r_din_ready;
  assign o_dout          = r_dout;
  assign o_dout_valid    = r_dout_valid;
  assign o_mul_din1      = r_mul_din1;
  assign o_mul_din2      = r_mul_din2;
  assign o_mul_din_valid = r_mul_din_valid;
  assign o_add_din1      = r_add_din1;
  assign o_add_din2      = r_add_din2;
  assign o_add_din_valid = r_add_din_valid;
  assign o_busy          = r_busy;
  assign o_timeout_err   = r_timeout_err;

endmodule
